// File: rtl/spi_pkg.sv
// Shared definitions for the write-only SPI master.
//   spi_state_e  : transfer FSM states
//   SPI_DATA_W   : default word length in bits
//   SPI_CLK_DIV  : default number of clk cycles per SCLK half-period
package spi_pkg;

  localparam int SPI_DATA_W  = 12;
  localparam int SPI_CLK_DIV = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter that toggles sclk every CLK_DIV clks
// while enabled, and holds count 0 / sclk low while disabled.
// Ports:
//   clk, rst   : system clock, async active-high reset
//   enable     : run the counter (high while shifting)
//   sclk       : registered serial clock, idles low
//   rise_stb   : high on the clk edge at which sclk goes 0 -> 1
//   fall_stb   : high on the clk edge at which sclk goes 1 -> 0
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tc;

  // Strobes are decoded from the terminal count so the FSM acts on the same
  // edge that toggles sclk; mosi therefore changes exactly with the fall.
  always_comb begin
    tc       = enable && (cnt_q == TERM);
    rise_stb = tc && !sclk_q;
    fall_stb = tc && sclk_q;
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;
    if (!enable) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_tx.sv
// Write-only SPI master, mode 0, MSB first. One DATA_W-bit word per
// transfer, framed by an active-low chip select.
// Ports:
//   clk, rst : system clock, async active-high reset
//   start    : transfer request, sampled while idle
//   din      : word to send, captured when start is accepted
//   cs       : chip select, active low
//   mosi     : serial data out
//   done     : one-clk pulse as cs returns high
//   sclk     : serial clock, idles low
//
// state | meaning
// IDLE  | cs high, waiting for start
// SHIFT | cs low, sclk running, one bit per sclk period
// DONE  | cs high again, done pulse for one clk
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              cs,
  output logic              mosi,
  output logic              done,
  output logic              sclk
);

  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              fall_stb;
  // The slave samples on the rising edge; the master has nothing to do there.
  logic              rise_stb_unused;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (state_q == SHIFT),
    .sclk     (sclk),
    .rise_stb (rise_stb_unused),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        if (start) begin
          shift_d   = din;
          cs_d      = 1'b0;
          mosi_d    = din[DATA_W-1];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_stb) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            shift_d = shift_q << 1;
            mosi_d  = shift_d[DATA_W-1];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign cs   = cs_q;
  assign mosi = mosi_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a 12-bit / CLK_DIV=10 instance and an
// 8-bit / CLK_DIV=1 instance, checked by a scoreboard monitor.
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [11:0] din0;
  logic [7:0]  din1;
  logic cs0, mosi0, done0, sclk0;
  logic cs1, mosi1, done1, sclk1;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_W(12), .CLK_DIV(10)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .din(din0),
    .cs(cs0), .mosi(mosi0), .done(done0), .sclk(sclk0)
  );

  spi_master_tx #(.DATA_W(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1),
    .cs(cs1), .mosi(mosi1), .done(done1), .sclk(sclk1)
  );

  typedef struct {
    int          inst;
    logic [15:0] word;
    int          nbits;
    int          cs_len;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] cs_v, sclk_v, mosi_v, done_v;
  assign cs_v   = {cs1, cs0};
  assign sclk_v = {sclk1, sclk0};
  assign mosi_v = {mosi1, mosi0};
  assign done_v = {done1, done0};

  logic [15:0] acc [2];
  int          rises [2];
  int          cs_low [2];
  int          cs_high [2];
  int          last_gap [2];
  int          done_cnt [2];
  logic        prev_sclk [2];
  logic        idle_sclk_err [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int inst, input logic [15:0] word, input int nbits, input int cs_len);
    exp_t e;
    e.inst   = inst;
    e.word   = word;
    e.nbits  = nbits;
    e.cs_len = cs_len;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int i, input int budget);
    int c0 = done_cnt[i];
    int n  = 0;
    while (done_cnt[i] == c0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (done_cnt[i] == c0) begin
      n_bad++;
      $display("FAIL done_timeout inst%0d: no done within %0d clks", i, budget);
    end
  endtask

  // Monitor: rebuilds each word from mosi at sclk rising edges and checks it
  // against the scoreboard when done pulses.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        acc[i]     = '0;
        rises[i]   = 0;
        cs_low[i]  = 0;
        cs_high[i] = 0;
      end else begin
        if (!cs_v[i]) begin
          if (cs_high[i] != 0) begin
            last_gap[i] = cs_high[i];
            cs_high[i]  = 0;
          end
          cs_low[i]++;
          if (sclk_v[i] && !prev_sclk[i]) begin
            acc[i] = {acc[i][14:0], mosi_v[i]};
            rises[i]++;
          end
        end else begin
          cs_high[i]++;
          if (sclk_v[i]) idle_sclk_err[i] = 1'b1;
        end
        if (done_v[i]) begin
          done_cnt[i]++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done inst%0d: got done, want none", i);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("sb_inst%0d", i), i, e.inst);
            check($sformatf("sb_word%0d", i), acc[i], e.word);
            check($sformatf("sb_rises%0d", i), rises[i], e.nbits);
            check($sformatf("sb_cs_low%0d", i), cs_low[i], e.cs_len);
            check($sformatf("done_with_cs_high%0d", i), cs_v[i], 1);
          end
          acc[i]    = '0;
          rises[i]  = 0;
          cs_low[i] = 0;
        end
      end
      prev_sclk[i] = sclk_v[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    din0   = '0;
    din1   = '0;
    for (int i = 0; i < 2; i++) begin
      acc[i] = '0; rises[i] = 0; cs_low[i] = 0; cs_high[i] = 0;
      last_gap[i] = 0; done_cnt[i] = 0; prev_sclk[i] = 1'b0; idle_sclk_err[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs", cs0, 1);
    check("reset_sclk", sclk0, 0);
    check("reset_mosi", mosi0, 0);
    check("reset_done", done0, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic transfer 0xABC, start held 2 clks
    din0 = 12'hABC; start0 = 1'b1;
    push_exp(0, 16'hABC, 12, 240);
    @(posedge clk); #1;
    check("cs_fall_latency", cs0, 0);
    @(posedge clk);
    @(negedge clk) start0 = 1'b0;
    wait_done(0, 400);
    check("idle_cs", cs0, 1);
    check("idle_mosi", mosi0, 0);
    check("idle_sclk", sclk0, 0);
    check("idle_done", done0, 0);

    // Second transfer 0x123 after 100 clks
    repeat (100) @(posedge clk);
    @(negedge clk) begin din0 = 12'h123; start0 = 1'b1; end
    push_exp(0, 16'h123, 12, 240);
    @(negedge clk) start0 = 1'b0;
    wait_done(0, 400);

    // Busy protection: start and din changes mid-transfer are ignored
    d0 = done_cnt[0];
    @(negedge clk) begin din0 = 12'h5A5; start0 = 1'b1; end
    push_exp(0, 16'h5A5, 12, 240);
    @(negedge clk) start0 = 1'b0;
    repeat (50) @(negedge clk);
    start0 = 1'b1; din0 = 12'hFFF;
    repeat (2) @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 400);
    repeat (300) @(posedge clk);
    #1;
    check("busy_single_done", done_cnt[0] - d0, 1);

    // Back-to-back with start held high
    d0 = done_cnt[0];
    @(negedge clk) begin din0 = 12'h800; start0 = 1'b1; end
    push_exp(0, 16'h800, 12, 240);
    push_exp(0, 16'h001, 12, 240);
    @(posedge clk); #1;
    @(negedge clk) din0 = 12'h001;
    wait_done(0, 400);
    wait_done(0, 400);
    @(negedge clk) start0 = 1'b0;
    check("b2b_cs_gap", last_gap[0], 2);
    repeat (300) @(posedge clk);
    #1;
    check("b2b_two_dones", done_cnt[0] - d0, 2);
    check("b2b_idle_cs", cs0, 1);

    // Reset mid-transfer of 0xABC
    @(negedge clk) begin din0 = 12'hABC; start0 = 1'b1; end
    push_exp(0, 16'hABC, 12, 240);
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while (rises[0] < 6 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_bit5", (rises[0] >= 6), 1);
    d0 = done_cnt[0];
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_cs", cs0, 1);
    check("abort_sclk", sclk0, 0);
    check("abort_mosi", mosi0, 0);
    check("abort_done", done0, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt[0] - d0, 0);
    @(negedge clk) begin din0 = 12'hABC; start0 = 1'b1; end
    push_exp(0, 16'hABC, 12, 240);
    @(negedge clk) start0 = 1'b0;
    wait_done(0, 400);

    // 8-bit, CLK_DIV=1 instance
    @(negedge clk) begin din1 = 8'hC3; start1 = 1'b1; end
    push_exp(1, 16'h00C3, 8, 16);
    @(negedge clk) start1 = 1'b0;
    wait_done(1, 100);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("idle_sclk_low0", idle_sclk_err[0], 0);
    check("idle_sclk_low1", idle_sclk_err[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
